// File: rtl/lc3_mem_pkg.sv
// Shared encodings and defaults for the LC-3 MAR/MDR memory-interface stage.
// Pure declarations, so there is no latency and no backpressure at this level.
package lc3_mem_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/lc3_mem_timer.sv
// Counts ACCESS cycles and flags the TIMEOUT-th one. expired is combinational from the count.
// It has no backpressure: clr wins over inc, and the count parks at its final value.
module lc3_mem_timer
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // With the count at LAST, this is the TIMEOUT-th cycle spent waiting.
  assign expired = inc && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR stage. mem_req rises one edge after mio_en, and ready rises one edge after mem_ready.
// Backpressure: DONE holds until mio_en drops. Optional abort on timeout via LC3_MEM_TIMEOUT_EN.
module lc3_mem_if
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              gate_mdr,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              ready,
  output logic              err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              we_q, we_d;
  logic              expired;

`ifdef LC3_MEM_TIMEOUT_EN
  logic err_q, err_d;

  lc3_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != ST_ACCESS),
    .inc     (state_q == ST_ACCESS),
    .expired (expired)
  );

  assign err = err_q;
`else
  // TIMEOUT only matters when the abort timer is built in.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign expired        = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
`ifdef LC3_MEM_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld_mar) begin
          mar_d = bus_in;
        end
        if (mio_en) begin
          we_d    = r_w;
          state_d = ST_ACCESS;
        end else if (ld_mdr) begin
          mdr_d = bus_in;
        end
      end
      ST_ACCESS: begin
        // A completion on the same edge as expiry counts as a normal completion.
        if (mem_ready) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (expired) begin
          state_d = ST_DONE;
`ifdef LC3_MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      ST_DONE: begin
        if (!mio_en) begin
          state_d = ST_IDLE;
`ifdef LC3_MEM_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
`ifdef LC3_MEM_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign ready     = (state_q == ST_DONE);
  assign bus_out   = mdr_q;
  assign bus_oe    = gate_mdr;

endmodule
